// File: rtl/zsdram_responder_if.sv
// ---------------------------------------------------------------------------
// zsdram_responder_if
// SDRAM bus between an SDRAM controller (master) and the zsdram_responder
// device model (slave).
//   sdram_cke/cs_n/ras_n/cas_n/we_n : command bits, cmd[4:0] in that order
//   sdram_bank, sdram_addr          : bank and row/column/mode address
//   sdram_dq_in, sdram_ldqm/udqm    : write data and write byte masks
//   sdram_dq_out, sdram_dq_oe       : read data and its valid/drive flag
//   init_done, err, err_cnt, ar_cnt : responder status back to the controller
// ---------------------------------------------------------------------------
interface zsdram_responder_if;
   logic        sdram_cke;
   logic        sdram_cs_n;
   logic        sdram_ras_n;
   logic        sdram_cas_n;
   logic        sdram_we_n;
   logic [1:0]  sdram_bank;
   logic [12:0] sdram_addr;
   logic [15:0] sdram_dq_in;
   logic        sdram_ldqm;
   logic        sdram_udqm;
   logic [15:0] sdram_dq_out;
   logic        sdram_dq_oe;
   logic        init_done;
   logic        err;
   logic [7:0]  err_cnt;
   logic [15:0] ar_cnt;

   modport master (
      output sdram_cke, sdram_cs_n, sdram_ras_n, sdram_cas_n, sdram_we_n,
             sdram_bank, sdram_addr, sdram_dq_in, sdram_ldqm, sdram_udqm,
      input  sdram_dq_out, sdram_dq_oe, init_done, err, err_cnt, ar_cnt
   );

   modport slave (
      input  sdram_cke, sdram_cs_n, sdram_ras_n, sdram_cas_n, sdram_we_n,
             sdram_bank, sdram_addr, sdram_dq_in, sdram_ldqm, sdram_udqm,
      output sdram_dq_out, sdram_dq_oe, init_done, err, err_cnt, ar_cnt
   );
endinterface

// File: rtl/zsdram_responder.sv
// ---------------------------------------------------------------------------
// zsdram_responder
// SDRAM device model that sits opposite the SDRAM controller. It decodes the
// command stream, tracks init / mode register / open rows, stores write
// bursts in a small array, returns read bursts after the CAS latency and
// flags protocol violations.
//   clk   : command sampling clock (rising edge)
//   rst_n : asynchronous active-low reset
//   bus   : SDRAM bus, slave side (see zsdram_responder_if)
// ---------------------------------------------------------------------------
module zsdram_responder #(
   parameter int ROW_BITS = 4,
   parameter int COL_BITS = 5
) (
   input logic               clk,
   input logic               rst_n,
   zsdram_responder_if.slave bus
);
   localparam int IDX_W = 2 + ROW_BITS + COL_BITS;
   localparam int DEPTH = 1 << IDX_W;

   localparam logic [4:0] CMD_ACT  = 5'b10011;
   localparam logic [4:0] CMD_WR   = 5'b10100;
   localparam logic [4:0] CMD_RD   = 5'b10101;
   localparam logic [4:0] CMD_BSTP = 5'b10110;
   localparam logic [4:0] CMD_PR   = 5'b10010;
   localparam logic [4:0] CMD_AR   = 5'b10001;
   localparam logic [4:0] CMD_LMR  = 5'b10000;

   typedef enum logic [1:0] {ST_UNINIT, ST_PRECHARGED, ST_READY} initState_t;

   initState_t          initState_q, initState_d;
   logic [1:0]          arSeen_q, arSeen_d;
   logic [1:0]          blLog_q, blLog_d;
   logic                cl2_q, cl2_d;
   logic [3:0]          bankOpen_q, bankOpen_d;
   logic [ROW_BITS-1:0] bankRow_q [4];
   logic [ROW_BITS-1:0] bankRow_d [4];
   logic                bActive_q, bActive_d;
   logic                bWrite_q, bWrite_d;
   logic [1:0]          bBank_q, bBank_d;
   logic [ROW_BITS-1:0] bRow_q, bRow_d;
   logic [COL_BITS-1:0] bCol_q, bCol_d;
   logic [2:0]          bBeat_q, bBeat_d;
   logic                bAuto_q, bAuto_d;
   logic                apPend_q, apPend_d;
   logic [1:0]          apBank_q, apBank_d;
   logic [2:0]          pipeValid_q, pipeValid_d;
   logic [15:0]         pipeData_q [3];
   logic [15:0]         pipeData_d [3];
   logic                err_q, err_d;
   logic [7:0]          errCnt_q, errCnt_d;
   logic [15:0]         arCnt_q, arCnt_d;
   logic [15:0]         mem_q [DEPTH];

   logic [4:0]          cmd;
   logic [1:0]          bank;
   logic                a10;
   logic                ready;
   logic                inFlight;
   logic [2:0]          blMask;
   logic                errNow, termBurst, startBurst, issue, issueWrite;
   logic [IDX_W-1:0]    issueIdx;
   logic                unusedAddr;

   assign cmd = {bus.sdram_cke, bus.sdram_cs_n, bus.sdram_ras_n, bus.sdram_cas_n, bus.sdram_we_n};
   assign bank = bus.sdram_bank;
   assign a10 = bus.sdram_addr[10];
   assign ready = (initState_q == ST_READY);
   assign blMask = 3'((4'd1 << blLog_q) - 4'd1);
   // Read beats still ahead of the output tap; a WR now would collide with them.
   assign inFlight = pipeValid_q[0] | (~cl2_q & pipeValid_q[1]);
   assign unusedAddr = ^bus.sdram_addr;

   // Burst column: only the low log2(BL) bits advance and wrap.
   function automatic logic [COL_BITS-1:0] burstCol(input logic [COL_BITS-1:0] base,
                                                    input logic [2:0] beat,
                                                    input logic [1:0] blLg);
      logic [COL_BITS-1:0] mask;
      logic [COL_BITS-1:0] sum;
      mask = COL_BITS'((4'd1 << blLg) - 4'd1);
      sum  = base + COL_BITS'(beat);
      return (base & ~mask) | (sum & mask);
   endfunction

   // Next-state logic: command decode, init FSM, bank bookkeeping, burst
   // engine and read pipeline. CKE low freezes the burst and the pipeline.
   always_comb begin
      initState_d = initState_q;
      arSeen_d    = arSeen_q;
      blLog_d     = blLog_q;
      cl2_d       = cl2_q;
      bankOpen_d  = bankOpen_q;
      bankRow_d   = bankRow_q;
      bActive_d   = bActive_q;
      bWrite_d    = bWrite_q;
      bBank_d     = bBank_q;
      bRow_d      = bRow_q;
      bCol_d      = bCol_q;
      bBeat_d     = bBeat_q;
      bAuto_d     = bAuto_q;
      apPend_d    = 1'b0;
      apBank_d    = apBank_q;
      pipeValid_d = pipeValid_q;
      pipeData_d  = pipeData_q;
      arCnt_d     = arCnt_q;
      errCnt_d    = errCnt_q;
      errNow      = 1'b0;
      termBurst   = 1'b0;
      startBurst  = 1'b0;
      issue       = 1'b0;
      issueWrite  = 1'b0;
      issueIdx    = '0;

      // Auto-precharge scheduled by a burst that finished on the previous edge.
      if (apPend_q) bankOpen_d[apBank_q] = 1'b0;

      if (bus.sdram_cke) begin
         pipeValid_d   = {pipeValid_q[1:0], 1'b0};
         pipeData_d[2] = pipeData_q[1];
         pipeData_d[1] = pipeData_q[0];

         case (cmd)
            CMD_ACT: begin
               if (!ready || bankOpen_q[bank]) errNow = 1'b1;
               else begin
                  bankOpen_d[bank] = 1'b1;
                  bankRow_d[bank]  = bus.sdram_addr[ROW_BITS-1:0];
               end
            end
            CMD_RD, CMD_WR: begin
               if (!ready || !bankOpen_q[bank]) errNow = 1'b1;
               else begin
                  termBurst  = 1'b1;
                  startBurst = 1'b1;
                  if (cmd == CMD_WR && inFlight) begin
                     errNow      = 1'b1;
                     pipeValid_d = '0;
                  end
               end
            end
            CMD_BSTP: begin
               if (!ready) errNow = 1'b1;
               else termBurst = 1'b1;
            end
            CMD_PR: begin
               if (a10) bankOpen_d = '0;
               else bankOpen_d[bank] = 1'b0;
               if (a10 || bank == bBank_q) termBurst = 1'b1;
               if (a10 && initState_q == ST_UNINIT) initState_d = ST_PRECHARGED;
            end
            CMD_AR: begin
               if (|bankOpen_q) errNow = 1'b1;
               else begin
                  arCnt_d = arCnt_q + 16'd1;
                  if (initState_q == ST_PRECHARGED && arSeen_q != 2'd2) arSeen_d = arSeen_q + 2'd1;
               end
            end
            CMD_LMR: begin
               if (|bankOpen_q) errNow = 1'b1;
               else begin
                  if (!bus.sdram_addr[2]) blLog_d = bus.sdram_addr[1:0];
                  else begin
                     blLog_d = 2'd0;
                     errNow  = 1'b1;
                  end
                  case (bus.sdram_addr[6:4])
                     3'b010:  cl2_d = 1'b1;
                     3'b011:  cl2_d = 1'b0;
                     default: begin
                        cl2_d  = 1'b0;
                        errNow = 1'b1;
                     end
                  endcase
                  if (initState_q == ST_PRECHARGED && arSeen_q == 2'd2) initState_d = ST_READY;
               end
            end
            default: ;
         endcase

         if (bActive_q) begin
            if (termBurst) begin
               bActive_d = 1'b0;
               if (bAuto_q) bankOpen_d[bBank_q] = 1'b0;
            end else begin
               issue      = 1'b1;
               issueWrite = bWrite_q;
               issueIdx   = {bBank_q, bRow_q, burstCol(bCol_q, bBeat_q, blLog_q)};
               bBeat_d    = bBeat_q + 3'd1;
               if (bBeat_q == blMask) begin
                  bActive_d = 1'b0;
                  if (bAuto_q) begin
                     apPend_d = 1'b1;
                     apBank_d = bBank_q;
                  end
               end
            end
         end

         if (startBurst) begin
            issue      = 1'b1;
            issueWrite = (cmd == CMD_WR);
            issueIdx   = {bank, bankRow_q[bank], bus.sdram_addr[COL_BITS-1:0]};
            bWrite_d   = (cmd == CMD_WR);
            bBank_d    = bank;
            bRow_d     = bankRow_q[bank];
            bCol_d     = bus.sdram_addr[COL_BITS-1:0];
            bAuto_d    = a10;
            bBeat_d    = 3'd1;
            if (blLog_q == 2'd0) begin
               bActive_d = 1'b0;
               if (a10) begin
                  apPend_d = 1'b1;
                  apBank_d = bank;
               end
            end else begin
               bActive_d = 1'b1;
            end
         end

         if (issue && !issueWrite) begin
            pipeValid_d[0] = 1'b1;
            pipeData_d[0]  = mem_q[issueIdx];
         end
      end

      if (errNow && errCnt_q != 8'hFF) errCnt_d = errCnt_q + 8'd1;
      err_d = errNow;
   end

   // State register; reset clears everything including the read pipeline,
   // so dq_oe drops as soon as rst_n falls.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         initState_q <= ST_UNINIT;
         arSeen_q    <= '0;
         blLog_q     <= '0;
         cl2_q       <= 1'b0;
         bankOpen_q  <= '0;
         bankRow_q   <= '{default: '0};
         bActive_q   <= 1'b0;
         bWrite_q    <= 1'b0;
         bBank_q     <= '0;
         bRow_q      <= '0;
         bCol_q      <= '0;
         bBeat_q     <= '0;
         bAuto_q     <= 1'b0;
         apPend_q    <= 1'b0;
         apBank_q    <= '0;
         pipeValid_q <= '0;
         pipeData_q  <= '{default: '0};
         err_q       <= 1'b0;
         errCnt_q    <= '0;
         arCnt_q     <= '0;
      end else begin
         initState_q <= initState_d;
         arSeen_q    <= arSeen_d;
         blLog_q     <= blLog_d;
         cl2_q       <= cl2_d;
         bankOpen_q  <= bankOpen_d;
         bankRow_q   <= bankRow_d;
         bActive_q   <= bActive_d;
         bWrite_q    <= bWrite_d;
         bBank_q     <= bBank_d;
         bRow_q      <= bRow_d;
         bCol_q      <= bCol_d;
         bBeat_q     <= bBeat_d;
         bAuto_q     <= bAuto_d;
         apPend_q    <= apPend_d;
         apBank_q    <= apBank_d;
         pipeValid_q <= pipeValid_d;
         pipeData_q  <= pipeData_d;
         err_q       <= err_d;
         errCnt_q    <= errCnt_d;
         arCnt_q     <= arCnt_d;
      end
   end

   // Storage array; a DQM bit high protects its byte lane for that beat.
   always_ff @(posedge clk) begin
      if (issue && issueWrite) begin
         if (!bus.sdram_ldqm) mem_q[issueIdx][7:0]  <= bus.sdram_dq_in[7:0];
         if (!bus.sdram_udqm) mem_q[issueIdx][15:8] <= bus.sdram_dq_in[15:8];
      end
   end

   // Output tap sits CL-1 stages down the read pipeline.
   assign bus.sdram_dq_out = cl2_q ? pipeData_q[1] : pipeData_q[2];
   assign bus.sdram_dq_oe  = cl2_q ? pipeValid_q[1] : pipeValid_q[2];
   assign bus.init_done    = ready;
   assign bus.err          = err_q;
   assign bus.err_cnt      = errCnt_q;
   assign bus.ar_cnt       = arCnt_q;
endmodule

// File: doc/zsdram_responder.md
# zsdram_responder

Synthesizable SDRAM device responder for the single-photon-counter board's 16-bit SDRAM bus. It decodes the CKE/CS_N/RAS_N/CAS_N/WE_N command stream and tracks initialisation, the mode register, and per-bank open rows. It stores write bursts in a small on-chip array and returns read bursts after the programmed CAS latency. It sits opposite the SDRAM controller in loopback/emulation builds and checks the controller's protocol, flagging command violations.

## Interface
- ROW_BITS, 4: row address bits retained in storage; upper row bits alias.
- COL_BITS, 5: column bits retained; storage depth = 2^(2+ROW_BITS+COL_BITS) x 16.
- clk, input, 1: system clock; all commands are sampled on its rising edge.
- rst_n, input, 1: asynchronous, active-low reset.
- sdram_cke, sdram_cs_n, sdram_ras_n, sdram_cas_n, sdram_we_n, input, 1 each: command bits, concatenated in that order as cmd[4:0].
- sdram_bank, input, 2: bank address.
- sdram_addr, input, 13: row/column/mode address; A10 is the auto/all-bank precharge flag.
- sdram_dq_in, input, 16: write data.
- sdram_ldqm, sdram_udqm, input, 1 each: write byte masks.
- sdram_dq_out, output, 16: read data. Reset value 0.
- sdram_dq_oe, output, 1: high while a read beat is driven. Reset value 0.
- init_done, output, 1: initialisation sequence completed. Reset value 0.
- err, output, 1: one-cycle pulse on each protocol violation. Reset value 0.
- err_cnt, output, 8: saturating violation count. Reset value 0.
- ar_cnt, output, 16: wrapping count of accepted AUTO REFRESH commands. Reset value 0.

## Operation
- Command decode (cmd[4:0]):
  - NOP 10111, ACT 10011, WR 10100, RD 10101, BSTP 10110, PR 10010, AR 10001, LMR 10000.
  - CS_N=1 with CKE=1 is NOP.
  - CKE=0: the command is ignored, and the burst counter and read pipeline hold (clock suspend).
- Init FSM:
  - UNINIT --PR with A10=1--> PRECHARGED.
  - PRECHARGED --AR--> ar_seen++. LMR with ar_seen>=2 --> READY, and init_done=1.
  - Before READY, ACT/RD/WR/BSTP raise err and are otherwise ignored.
- LMR: latch the mode register.
  - BL = A[2:0]: 000→1, 001→2, 010→4, 011→8. Any other value raises err and selects BL=1.
  - CL = A[6:4]: 010→2, 011→3. Any other value raises err and selects CL=3.
  - A3 (interleave) is ignored; addressing is always sequential.
  - LMR while any bank is open raises err and is ignored.
  - Default after reset: BL=1, CL=3.
- Banks: each of the 4 banks has an open flag and a ROW_BITS row register.
  - ACT to an open bank raises err and is ignored.
  - RD/WR to a closed bank raises err and is ignored.
  - PR with A10=1 closes all banks; with A10=0 it closes sdram_bank.
  - AR with any bank open raises err; otherwise ar_cnt++.
- Storage index = {bank, row[ROW_BITS-1:0], col[COL_BITS-1:0]}.
  - Burst column: the low log2(BL) bits increment and wrap; the upper bits are fixed from the command.
- Write: beat 0 is taken from dq_in in the same cycle as WR; beats 1..BL-1 follow on consecutive cycles.
  - ldqm=1 blocks the write of bits [7:0] for that beat; udqm=1 blocks bits [15:8].
- Read: each beat's array read is issued in sequence, then delayed so it emerges CL cycles after its issue. DQM is ignored for reads.
- Burst termination: a burst ends at BL beats, or earlier on:
  - a new RD or WR (the new burst starts immediately);
  - BSTP;
  - PR to the bursting bank.
- Termination rules:
  - Read beats already issued still complete through the CL pipeline; no further beats are issued.
  - A WR issued while read beats are in flight raises err. The write proceeds, and the in-flight read beats are discarded (dq_oe forced to 0).
- Auto-precharge (A10=1 on RD/WR): the bank closes on the cycle after the last beat. A terminated burst closes the bank at termination.

## Timing
- Commands are sampled at edge T0. Bank and mode state update at T0.
- Read: beat k is driven on dq_out with dq_oe=1 after edge T0+CL-1+k, so the controller samples it at T0+CL+k.
  - Back-to-back RD commands produce gapless dq_oe.
- Write beat k is captured at T0+k; the array updates at that edge.
- A same-address RD issued at least 1 cycle after a write beat returns the new data.
- err pulses for exactly the cycle after the offending edge.
- Reset mid-burst: all state clears immediately. dq_oe drops asynchronously, and init must be repeated.

## Test plan
- Init PR(A10=1), AR, AR, LMR A=0x032 → init_done=1 one cycle later, BL=4, CL=3, ar_cnt=2, err_cnt=0.
- ACT bank1 row5; WR col 0x04, data 0x1111/0x2222/0x3333/0x4444; RD col 0x06 → beats 0x3333, 0x4444, 0x1111, 0x2222 with dq_oe=1 starting 3 edges after RD (column wrap).
- WR BL=1 of 0xABCD with udqm=1 over an existing 0x0000 → a later RD returns 0x00CD.
- RD with A10=1 at BL=4 → bank closed after beat 3; a later RD to that bank raises err and err_cnt increments.
- RD at BL=8, then BSTP 2 cycles later → exactly 2 beats driven and dq_oe low thereafter. With CL=2, the first beat appears 1 cycle earlier than at CL=3.
- ACT before init, then ACT to an already-open bank, then AR with a bank open → three err pulses, err_cnt=3, ar_cnt unchanged. Reset asserted mid-read → dq_oe=0 and init_done=0 at once.
